etc_block_fetcher_p: RTL and testbench
======================================

# etc_block_fetcher_p

Parametrised ETC2 source-block fetcher. It walks a compressed image of BLOCKS_X × BLOCKS_Y 4×4 blocks in raster order and reads each 64-bit block from a fixed-latency synchronous ROM. A two-entry prefetch buffer hides ROM latency, so consecutive blocks stream with zero bubbles. Each block is presented to the downstream pixel decoder/writer 16 times, once per pixel, through a valid/ready handshake with back-pressure.

## Interface
- BLOCKS_X, 32, blocks per image row (1..2^COORD_W)
- BLOCKS_Y, 32, block rows per image (1..2^COORD_W)
- COORD_W, 8, width of block coordinate outputs
- ADDR_W, 32, ROM address width
- BASE_ADDR, 0, ROM address of block 0
- ADDR_STRIDE, 8, address increment per block
- ROM_LAT, 1, ROM read latency in cycles (1..8)
- sclk  in  1  clock; all logic on rising edge
- rsrt  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins an image pass; ignored while busy
- rom_en  out  1  ROM read enable; one request per cycle max
- rom_addr  out  ADDR_W  ROM read address, valid when rom_en
- rom_data  in  64  ROM data, valid ROM_LAT cycles after the request cycle
- out_valid  out  1  block/pixel tuple on outputs is valid
- out_ready  in  1  consumer accepts the tuple (transfer = out_valid & out_ready)
- block_out  out  64  compressed block currently presented
- blockX_out  out  COORD_W  X coordinate of presented block
- blockY_out  out  COORD_W  Y coordinate of presented block
- pixIdx_out  out  4  pixel index 0..15 within presented block
- busy  out  1  pass in progress
- image_finished  out  1  level; last pixel of last block has transferred

## Operation
- Top FSM: IDLE → RUN on start; RUN → DONE on transfer of pixIdx 15 of block N-1 (N = BLOCKS_X·BLOCKS_Y); DONE → RUN on start. busy = (state==RUN).
- Entering RUN clears the fetch index, block coordinates, pixIdx, buffer and in-flight tracking, and drops image_finished.
- Fetch engine issues rom_en when state==RUN, fetch index < N, and (buffer entries + in-flight requests) < 2. rom_addr = BASE_ADDR + idx·ADDR_STRIDE, computed mod 2^ADDR_W. The index increments per request.
- In-flight tracking uses a ROM_LAT-deep valid shift register. rom_data is written into the buffer tail at the edge where the tag emerges.
- Buffer is a 2-entry FIFO of 64-bit blocks. block_out = head entry. out_valid = state==RUN and buffer not empty.
- Each transfer increments pixIdx. A transfer at pixIdx 15 wraps pixIdx to 0, pops the head, and advances coordinates: X+1, or X=0 and Y+1 when X==BLOCKS_X-1.
- A simultaneous buffer write and pop in the same cycle is legal. Occupancy stays unchanged and no data is lost.
- out_valid never drops without a transfer, except on reset. Outputs hold stable while out_valid & !out_ready.
- Reset mid-pass: all state clears immediately. ROM returns still in flight are discarded. The next pass requires start.

## Timing
- Reset values: rom_en 0, rom_addr BASE_ADDR, out_valid 0, block_out 0, blockX/Y_out 0, pixIdx_out 0, busy 0, image_finished 0; FSM in IDLE.
- start high in cycle 0 → busy and first rom_en in cycle 1 (addr BASE_ADDR) → second rom_en in cycle 2 → first out_valid in cycle 1+ROM_LAT+1.
- With out_ready held high, block k is presented for exactly 16 consecutive cycles. Block k+1 follows in the very next cycle with no gap. A whole pass takes 16·N cycles after the first out_valid.
- image_finished rises the cycle after the final transfer and holds until start or rsrt. out_valid is 0 in DONE.
- start during RUN has no effect. start in the same cycle as the final transfer is ignored, and the FSM still enters DONE.

## Test plan
- Default params, ROM_LAT=1, rom_data = address-derived pattern, out_ready=1 → first out_valid cycle 3; 16384 transfers with no gap; block 33 shows blockX=1, blockY=1, addr 0x108; image_finished after last transfer.
- BLOCKS_X=3, BLOCKS_Y=2, ROM_LAT=4 → coordinates (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); exactly 96 transfers; no bubble between blocks.
- Random out_ready (50%) → tuple stable while stalled; never more than 2 outstanding requests plus buffered blocks; every block presented exactly 16 times, in order.
- rsrt asserted asynchronously mid-block 5 with requests in flight → all outputs at reset values immediately; stale rom_data ignored; new start refetches from BASE_ADDR.
- BASE_ADDR=0xFFFFFFF8, ADDR_W=32 → second request address wraps to 0x00000000.
- start pulsed during RUN and again in DONE → first ignored; second begins a new pass with image_finished cleared.

Source files
------------

// File: rtl/etc_block_fetcher_p.sv
// ETC2 source-block fetcher: walks the image in raster order and streams each
// 64-bit block from a fixed-latency ROM, presenting it once per pixel.
module etc_block_fetcher_p #(
  parameter int unsigned       BLOCKS_X    = 32,
  parameter int unsigned       BLOCKS_Y    = 32,
  parameter int unsigned       COORD_W     = 8,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       ADDR_STRIDE = 8,
  parameter int unsigned       ROM_LAT     = 1
) (
  input  logic               sclk,
  input  logic               rsrt,
  input  logic               start,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [63:0]        rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        block_out,
  output logic [COORD_W-1:0] blockX_out,
  output logic [COORD_W-1:0] blockY_out,
  output logic [3:0]         pixIdx_out,
  output logic               busy,
  output logic               image_finished
);

  localparam int unsigned         NUM_BLOCKS = BLOCKS_X * BLOCKS_Y;
  localparam int unsigned         IDX_W      = $clog2(NUM_BLOCKS + 1);
  localparam logic [IDX_W-1:0]    IDX_END    = IDX_W'(NUM_BLOCKS);
  localparam logic [COORD_W-1:0]  X_LAST     = COORD_W'(BLOCKS_X - 1);
  localparam logic [COORD_W-1:0]  Y_LAST     = COORD_W'(BLOCKS_Y - 1);
  localparam logic [ADDR_W-1:0]   STRIDE     = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   fetch_idx;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [ROM_LAT-1:0] tag_sr;
  logic [63:0]        buf_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         buf_cnt;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [3:0]         pix_idx;
  logic               finished;

  logic               pass_start;
  logic               xfer;
  logic               block_done;
  logic               last_xfer;
  logic               ret_valid;
  logic [3:0]         inflight_cnt;
  logic               slot_free;

  assign pass_start = start && (state != S_RUN);
  assign xfer       = out_valid && out_ready;
  assign block_done = xfer && (pix_idx == 4'd15);
  assign last_xfer  = block_done && (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign ret_valid  = tag_sr[ROM_LAT-1];

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(ROM_LAT); i++) begin
      inflight_cnt = inflight_cnt + 4'(tag_sr[i]);
    end
  end

  // Buffered blocks plus outstanding requests never exceed the two buffer slots,
  // so every ROM return always has room to land.
  assign slot_free = (({2'b00, buf_cnt} + inflight_cnt) < 4'd2);

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_xfer) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    rom_en    = 1'b0;
    if (state == S_RUN) begin
      busy      = 1'b1;
      out_valid = (buf_cnt != 2'd0);
      rom_en    = (fetch_idx < IDX_END) && slot_free;
    end
  end

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      fetch_idx  <= '0;
      fetch_addr <= BASE_ADDR;
    end else if (pass_start) begin
      fetch_idx  <= '0;
      fetch_addr <= BASE_ADDR;
    end else if (rom_en) begin
      fetch_idx  <= fetch_idx + 1'b1;
      fetch_addr <= fetch_addr + STRIDE;
    end
  end

  // One tag per request; the tag leaving the last stage marks the cycle rom_data is valid.
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      tag_sr <= '0;
    end else if (pass_start) begin
      tag_sr <= '0;
    end else begin
      tag_sr[0] <= rom_en;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else if (pass_start) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (ret_valid) begin
        buf_mem[wr_ptr] <= rom_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (block_done) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({ret_valid, block_done})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      cur_x   <= '0;
      cur_y   <= '0;
      pix_idx <= '0;
    end else if (pass_start) begin
      cur_x   <= '0;
      cur_y   <= '0;
      pix_idx <= '0;
    end else if (xfer) begin
      pix_idx <= pix_idx + 4'd1;
      if (block_done) begin
        if (cur_x == X_LAST) begin
          cur_x <= '0;
          cur_y <= cur_y + 1'b1;
        end else begin
          cur_x <= cur_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      finished <= 1'b0;
    end else if (pass_start) begin
      finished <= 1'b0;
    end else if (last_xfer) begin
      finished <= 1'b1;
    end
  end

  assign rom_addr       = fetch_addr;
  assign block_out      = buf_mem[rd_ptr];
  assign blockX_out     = cur_x;
  assign blockY_out     = cur_y;
  assign pixIdx_out     = pix_idx;
  assign image_finished = finished;

endmodule

// File: tb/tb_etc_block_fetcher_p.sv
// Self-checking bench for etc_block_fetcher_p on a 3x2 image, ROM latency 3,
// base address placed so that the second request wraps to zero.
module tb_etc_block_fetcher_p;

  localparam int          BX     = 3;
  localparam int          BY     = 2;
  localparam int          NB     = BX * BY;
  localparam int          CW     = 4;
  localparam int          LAT    = 3;
  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;
  localparam int          STRIDE = 8;
  localparam int          FV     = LAT + 2;
  localparam int          LASTC  = FV + 16 * NB - 1;

  logic          sclk = 1'b0;
  logic          rsrt;
  logic          start;
  logic          rom_en;
  logic [31:0]   rom_addr;
  logic [63:0]   rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   block_out;
  logic [CW-1:0] bx;
  logic [CW-1:0] by;
  logic [3:0]    pix;
  logic          busy;
  logic          image_finished;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sclk = ~sclk;

  etc_block_fetcher_p #(
    .BLOCKS_X(BX), .BLOCKS_Y(BY), .COORD_W(CW), .ADDR_W(32),
    .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE), .ROM_LAT(LAT)
  ) dut (
    .sclk(sclk), .rsrt(rsrt), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
    .blockX_out(bx), .blockY_out(by), .pixIdx_out(pix),
    .busy(busy), .image_finished(image_finished)
  );

  function automatic logic [63:0] pattern(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  function automatic logic [31:0] blkAddr(input int k);
    return BASE + 32'(k * STRIDE);
  endfunction

  // ROM model: data for a request appears LAT cycles later and is not cleared by reset.
  logic [31:0] pipe_addr [LAT];
  logic        pipe_vld  [LAT];
  always @(posedge sclk) begin
    pipe_vld[0]  <= rom_en;
    pipe_addr[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld[i]  <= pipe_vld[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end
  assign rom_data = pipe_vld[LAT-1] ? pattern(pipe_addr[LAT-1]) : 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [3:0]  exp_pix;
    logic [63:0] exp_block;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input logic s, input logic r);
    start     = s;
    out_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rom_en"}, rom_en, 0);
    checkOutput({tag, "_rom_addr"}, rom_addr, BASE);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_block"}, block_out, 0);
    checkOutput({tag, "_x"}, bx, 0);
    checkOutput({tag, "_y"}, by, 0);
    checkOutput({tag, "_pix"}, pix, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_fin"}, image_finished, 0);
  endtask

  // Full pass with out_ready high; start is re-pulsed on the final transfer cycle.
  task automatic streamPass(input int reset_at);
    int   req;
    int   k;
    logic exp_v;
    req = 0;
    @(posedge sclk); #1 applyStimulus(1'b1, 1'b1);
    @(negedge sclk);
    checkOutput("c0_busy", busy, 0);
    for (int cyc = 1; cyc <= LASTC + 2; cyc++) begin
      @(posedge sclk); #1 applyStimulus(cyc == LASTC, 1'b1);
      @(negedge sclk);
      exp_v = (cyc >= FV) && (cyc <= LASTC);
      checkOutput($sformatf("s%0d_valid", cyc), out_valid, exp_v);
      checkOutput($sformatf("s%0d_busy", cyc), busy, cyc <= LASTC);
      checkOutput($sformatf("s%0d_fin", cyc), image_finished, cyc > LASTC);
      if (cyc <= 2) checkOutput($sformatf("s%0d_rom_en", cyc), rom_en, 1);
      if (rom_en) begin
        checkOutput($sformatf("s%0d_req_addr", cyc), rom_addr, blkAddr(req));
        req++;
      end
      if (exp_v) begin
        k = (cyc - FV) / 16;
        checkOutput($sformatf("s%0d_block", cyc), block_out, pattern(blkAddr(k)));
        checkOutput($sformatf("s%0d_x", cyc), bx, k % BX);
        checkOutput($sformatf("s%0d_y", cyc), by, k / BX);
        checkOutput($sformatf("s%0d_pix", cyc), pix, (cyc - FV) % 16);
      end
      if (cyc == reset_at) begin
        #2 rsrt = 1'b1;
        #1 checkReset("async_rst");
        @(posedge sclk); #1 rsrt = 1'b0;
        return;
      end
    end
    checkOutput("req_total", req, NB);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   exp_k;
    int   exp_pix;
    int   req_cnt;
    int   popped;
    logic done;

    vecs[0] = '{start:1'b0, ready:1'b0, exp_en:1'b1, exp_addr:32'hFFFF_FFF8, exp_valid:1'b0, exp_pix:4'd0, exp_block:64'h0};
    vecs[1] = '{start:1'b0, ready:1'b0, exp_en:1'b1, exp_addr:32'h0000_0000, exp_valid:1'b0, exp_pix:4'd0, exp_block:64'h0};
    vecs[2] = '{start:1'b1, ready:1'b0, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b0, exp_pix:4'd0, exp_block:64'h0};
    vecs[3] = '{start:1'b0, ready:1'b0, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b0, exp_pix:4'd0, exp_block:64'h0};
    vecs[4] = '{start:1'b0, ready:1'b0, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b1, exp_pix:4'd0, exp_block:64'h5A5AA5A2_00000007};
    vecs[5] = '{start:1'b1, ready:1'b0, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b1, exp_pix:4'd0, exp_block:64'h5A5AA5A2_00000007};
    vecs[6] = '{start:1'b0, ready:1'b1, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b1, exp_pix:4'd0, exp_block:64'h5A5AA5A2_00000007};
    vecs[7] = '{start:1'b0, ready:1'b1, exp_en:1'b0, exp_addr:32'h0, exp_valid:1'b1, exp_pix:4'd1, exp_block:64'h5A5AA5A2_00000007};

    rsrt = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge sclk);
    checkReset("reset");
    @(posedge sclk); #1 rsrt = 1'b0;

    $display("[TB] pass 1: startup table with stalls and ignored start");
    @(posedge sclk); #1 applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge sclk); #1 applyStimulus(vecs[i].start, vecs[i].ready);
      @(negedge sclk);
      checkOutput($sformatf("tbl%0d_rom_en", i), rom_en, vecs[i].exp_en);
      if (vecs[i].exp_en) checkOutput($sformatf("tbl%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
      checkOutput($sformatf("tbl%0d_valid", i), out_valid, vecs[i].exp_valid);
      checkOutput($sformatf("tbl%0d_busy", i), busy, 1);
      checkOutput($sformatf("tbl%0d_pix", i), pix, vecs[i].exp_pix);
      checkOutput($sformatf("tbl%0d_x", i), bx, 0);
      checkOutput($sformatf("tbl%0d_y", i), by, 0);
      if (vecs[i].exp_valid) checkOutput($sformatf("tbl%0d_block", i), block_out, vecs[i].exp_block);
    end

    $display("[TB] pass 1: random back-pressure to the end of the image");
    exp_k   = 0;
    exp_pix = 2;
    req_cnt = 2;
    popped  = 0;
    done    = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge sclk); #1 applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      @(negedge sclk);
      if (rom_en) begin
        checkOutput("rnd_req_addr", rom_addr, blkAddr(req_cnt));
        req_cnt++;
      end
      checkOutput("rnd_outstanding_le2", (req_cnt - popped) <= 2, 1);
      checkOutput("rnd_valid", out_valid, 1);
      checkOutput("rnd_block", block_out, pattern(blkAddr(exp_k)));
      checkOutput("rnd_x", bx, exp_k % BX);
      checkOutput("rnd_y", by, exp_k / BX);
      checkOutput("rnd_pix", pix, exp_pix);
      if (out_valid && out_ready) begin
        if (exp_pix == 15) begin
          exp_pix = 0;
          popped++;
          if (exp_k == NB - 1) done = 1'b1;
          else exp_k++;
        end else begin
          exp_pix++;
        end
      end
    end
    checkOutput("pass1_completed", done, 1);
    checkOutput("pass1_req_total", req_cnt, NB);
    @(posedge sclk); #1 applyStimulus(1'b0, 1'b1);
    @(negedge sclk);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_valid", out_valid, 0);
    checkOutput("done_fin", image_finished, 1);
    checkOutput("done_rom_en", rom_en, 0);

    $display("[TB] pass 2: restart from DONE, zero-bubble stream");
    streamPass(0);

    $display("[TB] pass 3: asynchronous reset mid-block with a request in flight");
    streamPass(FV + 16 * 4 + 2);
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge sclk); #1 applyStimulus(1'b0, 1'b1);
      @(negedge sclk);
      checkOutput("post_rst_valid", out_valid, 0);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_rom_en", rom_en, 0);
      checkOutput("post_rst_pix", pix, 0);
    end

    $display("[TB] pass 4: fresh pass after reset");
    streamPass(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
